// File: rtl/apb3_bridge_mux.sv
// -----------------------------------------------------------------------------
// apb3_bridge_mux
//   Registered APB3 interconnect. There is one APB3 target port, fed by the
//   MSS FIC master, and NUM_SLOTS initiator slots.
//   Every output comes straight from a flop, so no input reaches an output
//   through combinational logic.
//   The slot index is PADDR[SLOT_LSB+3:SLOT_LSB]. An unmapped or masked slot
//   returns PSLVERR one cycle after the master's setup phase.
//
// Optional feature (compile-time macro): APB_TIMEOUT_EN
//   Defined   : an access phase that waits TIMEOUT_CYCLES cycles without the
//               slave becoming ready is abandoned and answered with PSLVERR.
//   Undefined : the access phase waits indefinitely; TIMEOUT_CYCLES is unused.
//
// Ports
//   PCLK, PRESET            clock, asynchronous active-high reset
//   PSEL, PENABLE, PADDR,
//   PWRITE, PWDATA          master request
//   PRDATA, PREADY, PSLVERR master response (registered)
//   PSELS, PENABLES, PADDRS,
//   PWRITES, PWDATAS        slave-side request (registered)
//   PRDATAS, PREADYS,
//   PSLVERRS                slave responses, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module apb3_bridge_mux #(
   parameter int          DATA_WIDTH     = 32,
   parameter int          ADDR_WIDTH     = 32,
   parameter int          NUM_SLOTS      = 16,
   parameter int          SLOT_LSB       = 8,
   parameter logic [15:0] SLOT_MASK      = 16'hFFFF,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                            PCLK,
   input  logic                            PRESET,
   input  logic                            PSEL,
   input  logic                            PENABLE,
   input  logic [ADDR_WIDTH-1:0]           PADDR,
   input  logic                            PWRITE,
   input  logic [DATA_WIDTH-1:0]           PWDATA,
   output logic [DATA_WIDTH-1:0]           PRDATA,
   output logic                            PREADY,
   output logic                            PSLVERR,
   output logic [NUM_SLOTS-1:0]            PSELS,
   output logic                            PENABLES,
   output logic [ADDR_WIDTH-1:0]           PADDRS,
   output logic                            PWRITES,
   output logic [DATA_WIDTH-1:0]           PWDATAS,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATAS,
   input  logic [NUM_SLOTS-1:0]            PREADYS,
   input  logic [NUM_SLOTS-1:0]            PSLVERRS
);

   typedef enum logic [2:0] {IDLE, S_SETUP, S_ACCESS, RESP, ERR} state_t;

   state_t                  r_state, w_state_next;
   logic [3:0]              r_slot, w_slot_next;
   logic [NUM_SLOTS-1:0]    r_psels, w_psels_next;
   logic                    r_penables, w_penables_next;
   logic [ADDR_WIDTH-1:0]   r_paddrs, w_paddrs_next;
   logic                    r_pwrites, w_pwrites_next;
   logic [DATA_WIDTH-1:0]   r_pwdatas, w_pwdatas_next;
   logic [DATA_WIDTH-1:0]   r_prdata, w_prdata_next;
   logic                    r_pready, w_pready_next;
   logic                    r_pslverr, w_pslverr_next;

`ifdef APB_TIMEOUT_EN
   // Compare against limit-1 so the abandon decision is taken in the last
   // permitted access cycle, and the slave's ready in that cycle still wins.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]             r_tcnt, w_tcnt_next;
`endif

   // Slot decode for the incoming request, and selection for the latched slot.
   logic [3:0]              w_addr_slot;
   logic                    w_addr_ok;
   logic [NUM_SLOTS-1:0]    w_addr_onehot;
   logic [NUM_SLOTS-1:0]    w_cur_onehot;
   logic [DATA_WIDTH-1:0]   w_rdata_masked [NUM_SLOTS];
   logic [DATA_WIDTH-1:0]   w_sel_rdata;
   logic                    w_sel_ready;
   logic                    w_sel_err;

   assign w_addr_slot = PADDR[SLOT_LSB+3:SLOT_LSB];
   assign w_addr_ok   = (int'(w_addr_slot) < NUM_SLOTS) && SLOT_MASK[w_addr_slot];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign w_addr_onehot[gi]  = (w_addr_slot == 4'(gi));
         assign w_cur_onehot[gi]   = (r_slot == 4'(gi));
         assign w_rdata_masked[gi] = PRDATAS[gi*DATA_WIDTH +: DATA_WIDTH]
                                     & {DATA_WIDTH{w_cur_onehot[gi]}};
      end
   endgenerate

   // AND-OR mux: only the latched slot contributes, so other slots are ignored.
   always_comb begin
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_sel_rdata = w_sel_rdata | w_rdata_masked[i];
      end
   end

   assign w_sel_ready = |(PREADYS & w_cur_onehot);
   assign w_sel_err   = |(PSLVERRS & w_cur_onehot);

   // Next-state logic. Outputs are computed for the state being entered, so
   // that they come out of flops in the same cycle as that state.
   always_comb begin
      w_state_next    = r_state;
      w_slot_next     = r_slot;
      w_psels_next    = '0;
      w_penables_next = 1'b0;
      w_paddrs_next   = r_paddrs;
      w_pwrites_next  = r_pwrites;
      w_pwdatas_next  = r_pwdatas;
      w_prdata_next   = '0;
      w_pready_next   = 1'b0;
      w_pslverr_next  = 1'b0;
`ifdef APB_TIMEOUT_EN
      w_tcnt_next     = r_tcnt;
`endif
      case (r_state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               w_paddrs_next  = PADDR;
               w_pwrites_next = PWRITE;
               w_pwdatas_next = PWDATA;
               w_slot_next    = w_addr_slot;
               if (w_addr_ok) begin
                  w_state_next = S_SETUP;
                  w_psels_next = w_addr_onehot;
               end else begin
                  w_state_next   = ERR;
                  w_pready_next  = 1'b1;
                  w_pslverr_next = 1'b1;
               end
            end
         end
         S_SETUP: begin
            w_state_next    = S_ACCESS;
            w_psels_next    = w_cur_onehot;
            w_penables_next = 1'b1;
`ifdef APB_TIMEOUT_EN
            w_tcnt_next     = '0;
`endif
         end
         S_ACCESS: begin
            if (w_sel_ready) begin
               w_state_next   = RESP;
               w_pready_next  = 1'b1;
               w_prdata_next  = r_pwrites ? '0 : w_sel_rdata;
               w_pslverr_next = w_sel_err;
`ifdef APB_TIMEOUT_EN
            end else if (r_tcnt == TMO_LAST) begin
               w_state_next   = ERR;
               w_pready_next  = 1'b1;
               w_pslverr_next = 1'b1;
`endif
            end else begin
`ifdef APB_TIMEOUT_EN
               w_tcnt_next     = r_tcnt + 16'd1;
`endif
               w_psels_next    = w_cur_onehot;
               w_penables_next = 1'b1;
            end
         end
         RESP:    w_state_next = IDLE;
         ERR:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state    <= IDLE;
         r_slot     <= '0;
         r_psels    <= '0;
         r_penables <= 1'b0;
         r_paddrs   <= '0;
         r_pwrites  <= 1'b0;
         r_pwdatas  <= '0;
         r_prdata   <= '0;
         r_pready   <= 1'b0;
         r_pslverr  <= 1'b0;
`ifdef APB_TIMEOUT_EN
         r_tcnt     <= '0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_slot     <= w_slot_next;
         r_psels    <= w_psels_next;
         r_penables <= w_penables_next;
         r_paddrs   <= w_paddrs_next;
         r_pwrites  <= w_pwrites_next;
         r_pwdatas  <= w_pwdatas_next;
         r_prdata   <= w_prdata_next;
         r_pready   <= w_pready_next;
         r_pslverr  <= w_pslverr_next;
`ifdef APB_TIMEOUT_EN
         r_tcnt     <= w_tcnt_next;
`endif
      end
   end

   assign PSELS    = r_psels;
   assign PENABLES = r_penables;
   assign PADDRS   = r_paddrs;
   assign PWRITES  = r_pwrites;
   assign PWDATAS  = r_pwdatas;
   assign PRDATA   = r_prdata;
   assign PREADY   = r_pready;
   assign PSLVERR  = r_pslverr;

endmodule

// File: tb/tb_apb3_bridge_mux.sv
// -----------------------------------------------------------------------------
// tb_apb3_bridge_mux
//   Self-checking bench for apb3_bridge_mux. A master task drives APB3 cycle by
//   cycle and plays the addressed slave. Every other slot is fed random values
//   on ready, error and data. Expected results come from a transaction-level
//   model: latency, read data, error and selected slot.
// -----------------------------------------------------------------------------
module tb_apb3_bridge_mux;

   localparam int          DW   = 32;
   localparam int          AW   = 32;
   localparam int          NS   = 14;          // slots 14/15 unmapped
   localparam logic [15:0] MASK = 16'hF7FF;    // slot 11 masked
   localparam int          TMO  = 8;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b0;
   logic              PSEL = 1'b0;
   logic              PENABLE = 1'b0;
   logic [AW-1:0]     PADDR = '0;
   logic              PWRITE = 1'b0;
   logic [DW-1:0]     PWDATA = '0;
   logic [DW-1:0]     PRDATA;
   logic              PREADY;
   logic              PSLVERR;
   logic [NS-1:0]     PSELS;
   logic              PENABLES;
   logic [AW-1:0]     PADDRS;
   logic              PWRITES;
   logic [DW-1:0]     PWDATAS;
   logic [NS*DW-1:0]  PRDATAS = '0;
   logic [NS-1:0]     PREADYS = '0;
   logic [NS-1:0]     PSLVERRS = '0;

   int checks = 0;
   int errors = 0;

   apb3_bridge_mux #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_LSB(8),
      .SLOT_MASK(MASK), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .PSELS(PSELS), .PENABLES(PENABLES), .PADDRS(PADDRS),
      .PWRITES(PWRITES), .PWDATAS(PWDATAS),
      .PRDATAS(PRDATAS), .PREADYS(PREADYS), .PSLVERRS(PSLVERRS)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      int            lat;
      logic [31:0]   rdata;
      logic          perr;
      logic [NS-1:0] sel;
   } exp_t;

   typedef struct packed {
      int            lat;          // cycles from master setup (T0) to PREADY
      logic [31:0]   rdata;
      logic          perr;
      logic [NS-1:0] sel_or;       // OR of PSELS over the transfer
      logic [NS-1:0] sel_at_rdy;   // PSELS in the PREADY cycle
      int            bad_sel;      // cycles with more than one PSELS bit
      int            first_sel;
      int            first_en;
      logic [31:0]   paddr_s;
      logic [31:0]   pwdata_s;
      logic          pwrite_s;
      int            idle_viol;    // PRDATA/PSLVERR non-zero while PREADY=0
   } obs_t;

   // Transaction-level reference model.
   function automatic exp_t model(input logic [31:0] addr, input bit wr, input int waits,
                                  input logic [31:0] sdata, input bit serr, input bit never_rdy);
      exp_t          e;
      logic [15:0]   m = MASK;
      logic [NS-1:0] one = 1;
      int            s = int'(addr[11:8]);
      bit            mapped = (s < NS) && m[s];
      bit            timed = 1'b0;
`ifdef APB_TIMEOUT_EN
      timed = mapped && (never_rdy || waits >= TMO);
`else
      timed = never_rdy && 1'b0;
`endif
      if (!mapped) begin
         e.lat = 1; e.rdata = '0; e.perr = 1'b1; e.sel = '0;
      end else if (timed) begin
         e.lat = 2 + TMO; e.rdata = '0; e.perr = 1'b1; e.sel = one << s;
      end else begin
         e.lat = 3 + waits; e.rdata = wr ? 32'h0 : sdata; e.perr = serr; e.sel = one << s;
      end
      return e;
   endfunction

   task automatic drive_slaves(input int tgt, input bit rdy, input logic [31:0] data, input bit err);
      for (int i = 0; i < NS; i++) begin
         if (i == tgt) begin
            PREADYS[i]           = rdy;
            PRDATAS[i*DW +: DW]  = rdy ? data : $urandom;
            PSLVERRS[i]          = rdy ? err : 1'($urandom);
         end else begin
            PREADYS[i]           = 1'($urandom);
            PRDATAS[i*DW +: DW]  = $urandom;
            PSLVERRS[i]          = 1'($urandom);
         end
      end
   endtask

   // Runs one master transfer starting now (just after a rising edge) and
   // plays the addressed slave. Returns in the cycle after PREADY, with the
   // bus idle, so a following call is back-to-back.
   task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] sdata, input bit serr,
                           input bit never_rdy, input bit drop_psel, output obs_t o);
      int tgt = int'(addr[11:8]);
      int acc = 0;
      bit rdy;
      if (tgt >= NS) tgt = -1;
      o = '0;
      o.lat = -1; o.first_sel = -1; o.first_en = -1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
      drive_slaves(tgt, 1'b0, sdata, serr);
      for (int c = 1; c <= 100 && o.lat < 0; c++) begin
         @(posedge PCLK); #1;
         PENABLE = 1'b1;
         if (drop_psel && c >= 2) begin PSEL = 1'b0; PENABLE = 1'b0; end
         o.sel_or = o.sel_or | PSELS;
         if ($countones(PSELS) > 1) o.bad_sel++;
         if (PSELS != 0 && o.first_sel < 0) o.first_sel = c;
         if (PENABLES && o.first_en < 0) begin
            o.first_en = c; o.paddr_s = PADDRS; o.pwdata_s = PWDATAS; o.pwrite_s = PWRITES;
         end
         if (PREADY) begin
            o.lat = c; o.rdata = PRDATA; o.perr = PSLVERR; o.sel_at_rdy = PSELS;
         end else if (PRDATA !== '0 || PSLVERR !== 1'b0) begin
            o.idle_viol++;
         end
         rdy = 1'b0;
         if (tgt >= 0 && PSELS[tgt] && PENABLES) begin
            acc++;
            rdy = !never_rdy && (acc > waits);
         end
         drive_slaves(tgt, rdy, sdata, serr);
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      drive_slaves(-1, 1'b0, 32'h0, 1'b0);
      $display("xfer addr=%08h wr=%0d waits=%0d lat=%0d rdata=%08h perr=%0d sel=%h",
               addr, wr, waits, o.lat, o.rdata, o.perr, o.sel_or);
   endtask

   task automatic test_reset;
      logic [NS+AW+2*DW+5-1:0] all_out;
      PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      all_out = {PSELS, PENABLES, PADDRS, PWRITES, PWDATAS, PRDATA, PREADY, PSLVERR, 2'b00};
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", all_out); end
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      checks++;
      if (PREADY !== 1'b0 || PSELS !== '0) begin
         errors++; $display("FAIL reset_release_idle pready=%b psels=%h want 0/0", PREADY, PSELS);
      end
   endtask

   task automatic test_write_zero_wait;
      obs_t o;
      exp_t e = model(32'h0000_0304, 1'b1, 0, 32'h0, 1'b0, 1'b0);
      apb_xfer(32'h0000_0304, 1'b1, 32'hA5A5_5A5A, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, o);
      checks++; if (o.first_sel !== 1) begin errors++; $display("FAIL wr_sel_cycle got=%0d want=1", o.first_sel); end
      checks++; if (o.sel_or !== e.sel) begin errors++; $display("FAIL wr_psels got=%h want=%h", o.sel_or, e.sel); end
      checks++; if (o.first_en !== 2) begin errors++; $display("FAIL wr_en_cycle got=%0d want=2", o.first_en); end
      checks++; if (o.pwdata_s !== 32'hA5A5_5A5A) begin errors++; $display("FAIL wr_pwdatas got=%h want=a5a55a5a", o.pwdata_s); end
      checks++; if (o.pwrite_s !== 1'b1) begin errors++; $display("FAIL wr_pwrites got=%b want=1", o.pwrite_s); end
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL wr_latency got=%0d want=%0d", o.lat, e.lat); end
      checks++; if (o.perr !== e.perr || o.rdata !== e.rdata) begin
         errors++; $display("FAIL wr_resp got=%b/%h want=%b/%h", o.perr, o.rdata, e.perr, e.rdata); end
      // One idle cycle: slave-side request fields keep their last values.
      @(posedge PCLK); #1;
      checks++; if (PADDRS !== 32'h0000_0304 || PWDATAS !== 32'hA5A5_5A5A || PSELS !== '0 || PREADY !== 1'b0) begin
         errors++; $display("FAIL idle_hold paddrs=%h pwdatas=%h psels=%h pready=%b", PADDRS, PWDATAS, PSELS, PREADY); end
   endtask

   task automatic test_read_waits;
      obs_t o;
      exp_t e = model(32'h0000_0C10, 1'b0, 2, 32'h1234_5678, 1'b0, 1'b0);
      apb_xfer(32'h0000_0C10, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0, 1'b0, o);
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rd_latency got=%0d want=%0d", o.lat, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rd_data got=%h want=%h", o.rdata, e.rdata); end
      checks++; if (o.perr !== e.perr) begin errors++; $display("FAIL rd_err got=%b want=%b", o.perr, e.perr); end
      checks++; if (o.sel_or !== e.sel) begin errors++; $display("FAIL rd_psels got=%h want=%h", o.sel_or, e.sel); end
   endtask

   task automatic test_unmapped;
      obs_t        o;
      exp_t        e;
      logic [31:0] addrs [3] = '{32'h0000_0F00, 32'h0000_0E44, 32'h0000_0B00};
      for (int k = 0; k < 3; k++) begin
         e = model(addrs[k], 1'b0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
         apb_xfer(addrs[k], 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, o);
         checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL unmapped_latency addr=%h got=%0d want=%0d", addrs[k], o.lat, e.lat); end
         checks++; if (o.perr !== 1'b1 || o.rdata !== 32'h0) begin
            errors++; $display("FAIL unmapped_resp addr=%h got=%b/%h want=1/0", addrs[k], o.perr, o.rdata); end
         checks++; if (o.sel_or !== '0) begin errors++; $display("FAIL unmapped_psels addr=%h got=%h want=0", addrs[k], o.sel_or); end
      end
   endtask

   task automatic test_slave_error;
      obs_t o;
      exp_t e = model(32'h0000_0620, 1'b0, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
      apb_xfer(32'h0000_0620, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, o);
      checks++; if (o.perr !== e.perr || o.rdata !== e.rdata) begin
         errors++; $display("FAIL slverr_resp got=%b/%h want=%b/%h", o.perr, o.rdata, e.perr, e.rdata); end
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL slverr_latency got=%0d want=%0d", o.lat, e.lat); end
   endtask

   task automatic test_psel_drop;
      obs_t o;
      exp_t e = model(32'h0000_0208, 1'b0, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
      apb_xfer(32'h0000_0208, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, o);
      checks++; if (o.lat !== e.lat || o.rdata !== e.rdata) begin
         errors++; $display("FAIL psel_drop got=%0d/%h want=%0d/%h", o.lat, o.rdata, e.lat, e.rdata); end
   endtask

   task automatic test_back_to_back_random;
      obs_t        o;
      exp_t        e;
      logic [31:0] addr, wdata, sdata;
      bit          wr, serr;
      int          waits;
      bit          mapped;
      for (int n = 0; n < 40; n++) begin
         addr  = {20'h0, 4'($urandom_range(0, 15)), 8'($urandom)};
         wr    = 1'($urandom);
         wdata = $urandom;
         sdata = $urandom;
         serr  = ($urandom_range(0, 3) == 0);
         waits = $urandom_range(0, 3);
         e = model(addr, wr, waits, sdata, serr, 1'b0);
         mapped = (e.sel != '0);
         apb_xfer(addr, wr, wdata, waits, sdata, serr, 1'b0, 1'b0, o);
         checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rnd_latency n=%0d got=%0d want=%0d", n, o.lat, e.lat); end
         checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, o.rdata, e.rdata); end
         checks++; if (o.perr !== e.perr) begin errors++; $display("FAIL rnd_perr n=%0d got=%b want=%b", n, o.perr, e.perr); end
         checks++; if (o.sel_or !== e.sel || o.bad_sel != 0 || o.sel_at_rdy !== '0) begin
            errors++; $display("FAIL rnd_psels n=%0d got=%h multi=%0d at_rdy=%h want=%h", n, o.sel_or, o.bad_sel, o.sel_at_rdy, e.sel); end
         checks++; if (o.idle_viol != 0) begin errors++; $display("FAIL rnd_idle_outputs n=%0d got=%0d want=0", n, o.idle_viol); end
         if (mapped) begin
            checks++; if (o.paddr_s !== addr || o.pwdata_s !== wdata || o.pwrite_s !== wr) begin
               errors++; $display("FAIL rnd_latched n=%0d got=%h/%h/%b want=%h/%h/%b", n, o.paddr_s, o.pwdata_s, o.pwrite_s, addr, wdata, wr); end
            checks++; if (o.first_sel !== 1 || o.first_en !== 2) begin
               errors++; $display("FAIL rnd_phase n=%0d got=%0d/%0d want=1/2", n, o.first_sel, o.first_en); end
         end
      end
   endtask

   task automatic test_async_reset;
      obs_t                    o;
      exp_t                    e;
      logic [NS+AW+2*DW+5-1:0] all_out;
      logic [NS-1:0]           one = 1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0500; PWRITE = 1'b0; PWDATA = 32'h1111_2222;
      drive_slaves(5, 1'b0, 32'h0, 1'b0);
      @(posedge PCLK); #1; PENABLE = 1'b1; drive_slaves(5, 1'b0, 32'h0, 1'b0);
      @(posedge PCLK); #1; drive_slaves(5, 1'b0, 32'h0, 1'b0);
      checks++; if (PSELS !== (one << 5) || PENABLES !== 1'b1) begin
         errors++; $display("FAIL areset_in_access psels=%h pen=%b want=%h/1", PSELS, PENABLES, one << 5); end
      #2 PRESET = 1'b1;
      #1;
      all_out = {PSELS, PENABLES, PADDRS, PWRITES, PWDATAS, PRDATA, PREADY, PSLVERR, 2'b00};
      checks++; if (all_out !== '0) begin errors++; $display("FAIL areset_outputs got=%h want=0", all_out); end
      @(posedge PCLK); #1;
      PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      drive_slaves(-1, 1'b0, 32'h0, 1'b0);
      @(posedge PCLK); #1;
      e = model(32'h0000_0004, 1'b0, 0, 32'h7777_1234, 1'b0, 1'b0);
      apb_xfer(32'h0000_0004, 1'b0, 32'h0, 0, 32'h7777_1234, 1'b0, 1'b0, 1'b0, o);
      checks++; if (o.lat !== e.lat || o.rdata !== e.rdata || o.perr !== e.perr) begin
         errors++; $display("FAIL areset_recover got=%0d/%h/%b want=%0d/%h/%b", o.lat, o.rdata, o.perr, e.lat, e.rdata, e.perr); end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout;
      obs_t o;
      exp_t e;
      e = model(32'h0000_0100, 1'b0, 0, 32'h9999_0000, 1'b0, 1'b1);
      apb_xfer(32'h0000_0100, 1'b0, 32'h0, 0, 32'h9999_0000, 1'b0, 1'b1, 1'b0, o);
      checks++; if (o.lat !== e.lat || o.perr !== 1'b1 || o.rdata !== 32'h0 || o.sel_at_rdy !== '0) begin
         errors++; $display("FAIL timeout got=%0d/%b/%h/%h want=%0d/1/0/0", o.lat, o.perr, o.rdata, o.sel_at_rdy, e.lat); end
      e = model(32'h0000_0200, 1'b0, 0, 32'h2222_3333, 1'b0, 1'b0);
      apb_xfer(32'h0000_0200, 1'b0, 32'h0, 0, 32'h2222_3333, 1'b0, 1'b0, 1'b0, o);
      checks++; if (o.lat !== e.lat || o.rdata !== e.rdata || o.perr !== e.perr) begin
         errors++; $display("FAIL timeout_next got=%0d/%h/%b want=%0d/%h/%b", o.lat, o.rdata, o.perr, e.lat, e.rdata, e.perr); end
      // Ready in the last allowed access cycle beats the timeout.
      e = model(32'h0000_0300, 1'b0, TMO - 1, 32'h4444_5555, 1'b0, 1'b0);
      apb_xfer(32'h0000_0300, 1'b0, 32'h0, TMO - 1, 32'h4444_5555, 1'b0, 1'b0, 1'b0, o);
      checks++; if (o.lat !== e.lat || o.rdata !== e.rdata || o.perr !== e.perr) begin
         errors++; $display("FAIL timeout_race got=%0d/%h/%b want=%0d/%h/%b", o.lat, o.rdata, o.perr, e.lat, e.rdata, e.perr); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_waits();
      test_unmapped();
      test_slave_error();
      test_psel_drop();
      test_back_to_back_random();
      test_async_reset();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
